// File: rtl/bcd_arb_pkg.sv
// Shared types, constants and digit helpers for the BCD converter arbiter.
package bcd_arb_pkg;

  localparam int unsigned BCD_VAL_W = 14;
  localparam logic [13:0] BCD_MAX   = 14'd9999;
  localparam logic [3:0]  BCD_BLANK = 4'hF;

  localparam logic [13:0] DIG_T1 = 14'd10;
  localparam logic [13:0] DIG_T2 = 14'd100;
  localparam logic [13:0] DIG_T3 = 14'd1000;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ISSUE     = 3'd1;
  localparam state_t S_WAIT_BUSY = 3'd2;
  localparam state_t S_WAIT_DONE = 3'd3;
  localparam state_t S_PUBLISH   = 3'd4;

  function automatic logic [2:0] digit_count(input logic [13:0] v);
    if (v < DIG_T1)      return 3'd1;
    else if (v < DIG_T2) return 3'd2;
    else if (v < DIG_T3) return 3'd3;
    else                 return 3'd4;
  endfunction

  // Positions above the most significant digit of v become the blank code.
  function automatic logic [15:0] blank_digits(input logic [15:0] d, input logic [13:0] v);
    logic [15:0] r;
    logic [2:0]  n;
    r = d;
    n = digit_count(v);
    for (int unsigned k = 1; k < 4; k++) begin
      if (3'(k) >= n) r[4*k +: 4] = BCD_BLANK;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above the last grant.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      grant
);

  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!valid && req[(32'(last) + i) % NREQ]) begin
        valid = 1'b1;
        grant = 2'((32'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/bcd_arbiter.sv
// Round-robin arbiter sharing one sequential BCD converter among NREQ requesters.
// Define BCD_ARB_BLANK_EN for leading-zero blanking on res_digits.
module bcd_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*14-1:0]   req_value,
  output logic [NREQ-1:0]      ack,
  output logic                 res_valid,
  output logic [1:0]           res_id,
  output logic [15:0]          res_digits,
  output logic                 res_ovf,
  output logic                 busy,
  output logic                 conv_start,
  output logic [13:0]          conv_value,
  input  logic                 conv_ready,
  input  logic [3:0]           conv_a,
  input  logic [3:0]           conv_b,
  input  logic [3:0]           conv_c,
  input  logic [3:0]           conv_d
);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  gid;
  logic        ovf_q;
  logic        pick_valid;
  logic [1:0]  pick_id;
  logic [13:0] sel_value;
  logic [15:0] raw_digits;
  logic [15:0] shaped_digits;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (ptr),
    .valid (pick_valid),
    .grant (pick_id)
  );

  always_comb begin
    sel_value = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_id == 2'(i)) sel_value = req_value[14*i +: 14];
    end
  end

  assign raw_digits = {conv_d, conv_c, conv_b, conv_a};

`ifdef BCD_ARB_BLANK_EN
  assign shaped_digits = blank_digits(raw_digits, conv_value);
`else
  assign shaped_digits = raw_digits;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= 2'(NREQ - 1);
      gid        <= '0;
      ovf_q      <= 1'b0;
      conv_value <= '0;
      res_id     <= '0;
      res_digits <= 16'hFFFF;
      res_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (conv_ready && pick_valid) begin
            gid <= pick_id;
            if (sel_value > BCD_MAX) begin
              conv_value <= BCD_MAX;
              ovf_q      <= 1'b1;
            end else begin
              conv_value <= sel_value;
              ovf_q      <= 1'b0;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!conv_ready) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (conv_ready) begin
            res_digits <= shaped_digits;
            res_id     <= gid;
            res_ovf    <= ovf_q;
            state      <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          ptr   <= gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign conv_start = (state == S_ISSUE);
  assign res_valid  = (state == S_PUBLISH);

  always_comb begin
    ack = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ack[i] = res_valid && (gid == 2'(i));
    end
  end

endmodule

// File: tb/tb_bcd_arbiter.sv
// Self-checking bench for bcd_arbiter with a behavioural converter and result model.
module tb_bcd_arbiter;

  localparam int NREQ = 4;

`ifdef BCD_ARB_BLANK_EN
  localparam logic [15:0] EXP_42  = 16'hFF42;
  localparam logic [15:0] EXP_0   = 16'hFFF0;
  localparam logic [15:0] EXP_321 = 16'hF321;
  localparam logic [15:0] EXP_77  = 16'hFF77;
`else
  localparam logic [15:0] EXP_42  = 16'h0042;
  localparam logic [15:0] EXP_0   = 16'h0000;
  localparam logic [15:0] EXP_321 = 16'h0321;
  localparam logic [15:0] EXP_77  = 16'h0077;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*14-1:0] req_value;
  logic [NREQ-1:0]   ack;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [15:0]       res_digits;
  logic              res_ovf;
  logic              busy;
  logic              conv_start;
  logic [13:0]       conv_value;
  logic              conv_ready;
  logic [3:0]        conv_a, conv_b, conv_c, conv_d;

  bcd_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_value(req_value),
    .ack(ack), .res_valid(res_valid), .res_id(res_id), .res_digits(res_digits),
    .res_ovf(res_ovf), .busy(busy), .conv_start(conv_start), .conv_value(conv_value),
    .conv_ready(conv_ready), .conv_a(conv_a), .conv_b(conv_b), .conv_c(conv_c),
    .conv_d(conv_d)
  );

  // Converter stand-in: goes busy for a fixed time, then shows all four digits.
  logic        cv_rdy;
  logic        hold_low;
  int          cv_cnt;
  logic [13:0] cv_val;
  assign conv_ready = cv_rdy & ~hold_low;

  always @(posedge clk) begin
    if (rst) begin
      cv_rdy <= 1'b1; cv_cnt <= 0; cv_val <= '0;
      conv_a <= '0; conv_b <= '0; conv_c <= '0; conv_d <= '0;
    end else if (cv_rdy && conv_start) begin
      cv_rdy <= 1'b0; cv_cnt <= 5; cv_val <= conv_value;
    end else if (!cv_rdy) begin
      if (cv_cnt == 0) begin
        cv_rdy <= 1'b1;
        conv_a <= 4'(cv_val % 10);
        conv_b <= 4'((cv_val / 10) % 10);
        conv_c <= 4'((cv_val / 100) % 10);
        conv_d <= 4'((cv_val / 1000) % 10);
      end else begin
        cv_cnt <= cv_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int clampv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] exp_digits(input int v);
    int c;
    logic [15:0] d;
    c = clampv(v);
    d = {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
`ifdef BCD_ARB_BLANK_EN
    if (c < 10)        d[15:4]  = 12'hFFF;
    else if (c < 100)  d[15:8]  = 8'hFF;
    else if (c < 1000) d[15:12] = 4'hF;
`endif
    return d;
  endfunction

  // Model state: who must be served next, and what was observed.
  int          m_last = NREQ - 1;
  bit          outstanding = 0;
  int          pred_id = 0;
  int          pred_val = 0;
  int          n_results = 0;
  int          n_starts = 0;
  int          last_id = 0;
  logic [15:0] last_digits = '0;
  logic        last_ovf = 1'b0;
  logic [13:0] last_conv = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_last = NREQ - 1;
      outstanding = 0;
    end else begin
      if (conv_start) begin
        int found;
        found = -1;
        chk("start_while_busy", 32'(outstanding), 32'd0);
        chk("start_while_not_ready", 32'(hold_low), 32'd0);
        for (int k = 1; k <= NREQ; k++) begin
          if (found < 0 && req[(m_last + k) % NREQ]) found = (m_last + k) % NREQ;
        end
        chk("start_without_req", 32'(found >= 0), 32'd1);
        pred_id  = (found < 0) ? 0 : found;
        pred_val = int'(req_value[14*pred_id +: 14]);
        chk("conv_value", 32'(conv_value), 32'(clampv(pred_val)));
        last_conv = conv_value;
        n_starts++;
        outstanding = 1;
      end
      if (outstanding) chk("busy", 32'(busy), 32'd1);
      if (res_valid) begin
        chk("result_expected", 32'(outstanding), 32'd1);
        chk("res_id", 32'(res_id), 32'(pred_id));
        chk("ack", 32'(ack), 32'(1 << pred_id));
        chk("res_digits", 32'(res_digits), 32'(exp_digits(pred_val)));
        chk("res_ovf", 32'(res_ovf), 32'(pred_val > 9999));
        last_id = int'(res_id);
        last_digits = res_digits;
        last_ovf = res_ovf;
        m_last = pred_id;
        outstanding = 0;
        n_results++;
      end else begin
        chk("ack_idle", 32'(ack), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_result(input string name);
    int r0;
    int t;
    r0 = n_results;
    t = 0;
    while (n_results == r0 && t < 60) begin
      tick();
      t++;
    end
    if (n_results == r0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ack"}, 32'(ack), 32'd0);
    chk({name, "_valid"}, 32'(res_valid), 32'd0);
    chk({name, "_start"}, 32'(conv_start), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_ovf"}, 32'(res_ovf), 32'd0);
    chk({name, "_id"}, 32'(res_id), 32'd0);
    chk({name, "_digits"}, 32'(res_digits), 32'hFFFF);
    chk({name, "_convval"}, 32'(conv_value), 32'd0);
  endtask

  task automatic serve(input int id, input int val, input string name);
    req_value[14*id +: 14] = 14'(val);
    req[id] = 1'b1;
    wait_result(name);
    req[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int s0;
    rst = 1'b1; req = '0; req_value = '0; hold_low = 1'b0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    s0 = n_starts;
    serve(0, 1234, "single");
    chk("single_id", 32'(last_id), 32'd0);
    chk("single_digits", 32'(last_digits), 32'h1234);
    chk("single_ovf", 32'(last_ovf), 32'd0);
    chk("single_starts", 32'(n_starts - s0), 32'd1);

    serve(2, 12000, "clamp");
    chk("clamp_conv", 32'(last_conv), 32'd9999);
    chk("clamp_digits", 32'(last_digits), 32'h9999);
    chk("clamp_ovf", 32'(last_ovf), 32'd1);
    chk("clamp_id", 32'(last_id), 32'd2);

    serve(1, 1234, "prior");
    serve(1, 42, "v42");
    chk("v42_digits", 32'(last_digits), 32'(EXP_42));
    serve(1, 0, "v0");
    chk("v0_digits", 32'(last_digits), 32'(EXP_0));

    pulse_reset();
    for (int i = 0; i < NREQ; i++) req_value[14*i +: 14] = 14'(100 * i + 7);
    req = '1;
    for (int n = 0; n < 8; n++) begin
      wait_result("fair");
      chk("fair_order", 32'(last_id), 32'(n % NREQ));
    end
    req = '0;
    repeat (4) tick();

    req_value[14*3 +: 14] = 14'd5678;
    req[3] = 1'b1;
    for (int t = 0; t < 40 && !(busy && !conv_ready); t++) tick();
    chk("midconv_reached", 32'(busy && !conv_ready), 32'd1);
    tick();
    s0 = n_results;
    rst = 1'b1; req = '0;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_no_ack", 32'(n_results - s0), 32'd0);
    serve(3, 321, "after_rst");
    chk("after_rst_id", 32'(last_id), 32'd3);
    chk("after_rst_digits", 32'(last_digits), 32'(EXP_321));

    hold_low = 1'b1;
    pulse_reset();
    s0 = n_starts;
    req_value[14*1 +: 14] = 14'd77;
    req[1] = 1'b1;
    repeat (5) tick();
    chk("late_no_start", 32'(n_starts - s0), 32'd0);
    chk("late_idle", 32'(busy), 32'd0);
    hold_low = 1'b0;
    wait_result("late");
    req[1] = 1'b0;
    chk("late_id", 32'(last_id), 32'd1);
    chk("late_digits", 32'(last_digits), 32'(EXP_77));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
